// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory request/response path: FSM encoding and
// bus widths.
package mem_if_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } mem_state_e;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned LAT_W  = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the CPU pipeline (master) and the
// memory responder (slave).
interface data_mem_responder_if;
  import mem_if_pkg::*;

  logic [DATA_W-1:0] Address;
  logic              MEMRead;
  logic              MEMWrite;
  logic [DATA_W-1:0] Write_data;
  logic [STRB_W-1:0] Write_strb;
  logic              MEM_Req_Ready;
  logic [DATA_W-1:0] Read_data;
  logic              Read_data_Valid;
  logic              Read_data_Ready;

  modport master (
    output Address, MEMRead, MEMWrite, Write_data, Write_strb, Read_data_Ready,
    input  MEM_Req_Ready, Read_data, Read_data_Valid
  );

  modport slave (
    input  Address, MEMRead, MEMWrite, Write_data, Write_strb, Read_data_Ready,
    output MEM_Req_Ready, Read_data, Read_data_Valid
  );

endinterface

// File: rtl/byte_wr_ram.sv
// Word array with byte-enabled synchronous write and asynchronous read.
module byte_wr_ram
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [STRB_W-1:0]     strb,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_W-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (strb[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts pipeline load/store requests, services them from a
// byte-strobed array after LATENCY busy cycles and returns load data over a handshake.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam logic [LAT_W-1:0] LatInit = LAT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

  mem_state_e        state_q;
  logic [LAT_W-1:0]  cnt_q;
  logic              rd_pend_q;
  logic [DATA_W-1:0] rd_buf_q;
  logic [DATA_W-1:0] read_data_q;
  logic              read_valid_q;

  logic                  req_ready;
  logic                  accept;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_W-1:0]     ram_rdata;
  logic                  unused_addr_bits;

  assign req_ready = (state_q == StIdle) & ~rst;
  assign accept    = req_ready & (bus.MEMRead | bus.MEMWrite);
  // A simultaneous read+write is treated as a write only.
  assign wr_en     = accept & bus.MEMWrite;
  assign idx       = bus.Address[ADDR_WIDTH+1:2];

  assign unused_addr_bits = ^{bus.Address[DATA_W-1:ADDR_WIDTH+2], bus.Address[1:0]};

  byte_wr_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .strb  (bus.Write_strb),
    .addr  (idx),
    .wdata (bus.Write_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      rd_pend_q    <= 1'b0;
      rd_buf_q     <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (bus.MEMWrite) begin
              rd_pend_q <= 1'b0;
              if (LATENCY != 0) begin
                state_q <= StBusy;
                cnt_q   <= LatInit;
              end
            end else begin
              rd_buf_q <= ram_rdata;
              if (LATENCY == 0) begin
                state_q      <= StResp;
                read_data_q  <= ram_rdata;
                read_valid_q <= 1'b1;
              end else begin
                state_q   <= StBusy;
                cnt_q     <= LatInit;
                rd_pend_q <= 1'b1;
              end
            end
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            if (rd_pend_q) begin
              state_q      <= StResp;
              read_data_q  <= rd_buf_q;
              read_valid_q <= 1'b1;
              rd_pend_q    <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (bus.Read_data_Ready) begin
            state_q      <= StIdle;
            read_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.MEM_Req_Ready   = req_ready;
  assign bus.Read_data       = read_data_q;
  assign bus.Read_data_Valid = read_valid_q;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CPU data-memory request interface: accepts the EX stage's read/write requests (`Address`, `MEMRead`, `MEMWrite`, `Write_data`, `Write_strb`) with a `MEM_Req_Ready` handshake. It services them from an internal byte-strobed word array with configurable latency, and returns load data to the MEM stage over a `Read_data`/`Read_data_Valid`/`Read_data_Ready` handshake. It sits between the pipeline and simulation/FPGA memory, replacing an ideal memory so stall paths are exercised.

## Interface
- `ADDR_WIDTH`, 10: word-index bits; array depth 2^ADDR_WIDTH words of 32 bits.
- `LATENCY`, 2: extra busy cycles per access, legal range 0..15.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Address` in 32: byte address, word-aligned by initiator.
- `MEMRead` in 1: read request.
- `MEMWrite` in 1: write request.
- `Write_data` in 32: write data, already lane-shifted.
- `Write_strb` in 4: per-byte write enable, bit i → `Write_data[8i+7:8i]`.
- `MEM_Req_Ready` out 1: request accepted when high with `MEMRead|MEMWrite`.
- `Read_data` out 32: load data, full word.
- `Read_data_Valid` out 1: `Read_data` valid.
- `Read_data_Ready` in 1: MEM stage consumes response.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset → IDLE, `cnt`=0, `Read_data`=0, `Read_data_Valid`=0. Array contents not reset.
- `MEM_Req_Ready` = (state==IDLE) & ~rst; combinational from state, so 0 in the reset cycle and 1 in the first cycle after reset.
- Accept = `MEM_Req_Ready & (MEMRead|MEMWrite)`. Index = `Address[ADDR_WIDTH+1:2]`. `Address[1:0]` and bits above the index are ignored, so upper addresses alias (wrap-around).
- Write accept: array bytes with strobe=1 are updated at the accepting edge; strobe=0 bytes are unchanged; `Write_strb`=0000 is a legal no-op. No response is generated. If LATENCY=0, stay IDLE; else go to BUSY with `cnt`=LATENCY-1.
- Read accept: the array word is captured into an internal data register at the accepting edge. If LATENCY=0, go to RESP; else go to BUSY with `cnt`=LATENCY-1 and a pending-read flag set.
- BUSY: decrement `cnt` each cycle. When `cnt`==0, go to RESP if a read is pending, else IDLE.
- RESP: `Read_data_Valid`=1 and `Read_data` = captured word, both held stable until `Read_data_Valid & Read_data_Ready`. On that edge, go to IDLE and clear `Read_data_Valid`. `Read_data` keeps its last value.
- `MEMRead` and `MEMWrite` asserted together: the write is performed and the read is dropped (no response).
- Requests presented outside IDLE are ignored; the initiator holds them until ready.
- Reset mid-operation: a pending read is discarded and no response is issued. A write already committed stays in the array.

## Timing
- Read accepted at edge E: `Read_data_Valid` is high in cycle E+LATENCY+1 (first cycle after edge E+LATENCY).
- Read occupancy: `MEM_Req_Ready` is low from cycle E+1 until the cycle after the response handshake. The minimum read-to-read spacing is LATENCY+2 cycles.
- Write occupancy: `MEM_Req_Ready` is low for exactly LATENCY cycles after acceptance. With LATENCY=0, back-to-back writes proceed every cycle.
- Read-after-write to the same word sees the new data, since the write commits before any later read can be accepted.
- No combinational path from `MEMRead`/`MEMWrite`/`Address` to any output.

## Structure
- Shared package `mem_if_pkg`: FSM state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), `DATA_W`=32, `STRB_W`=4, `LAT_W`=4.
- One sub-module, `byte_wr_ram`: synchronous-write, asynchronous-read 32-bit array with 4-bit byte enables, parameterised by `ADDR_WIDTH`. The FSM, counter and response register live in `data_mem_responder`.

## Test plan
- LATENCY=2: write 0xDEADBEEF to 0x10 with strb 1111, then read 0x10 → Valid rises 3 cycles after read accept, `Read_data`=0xDEADBEEF.
- Write 0x000000AA with strb 0001, then 0x0000BB00 with strb 0010, both to 0x20 over prior 0x11223344 → read returns 0x1122BBAA.
- Read with `Read_data_Ready` held low for 5 cycles → Valid and `Read_data` stay stable, `MEM_Req_Ready`=0 throughout; IDLE one cycle after Ready rises.
- LATENCY=0: four consecutive writes → accepted on four consecutive cycles. Then read 0x0 and 0x1000 with ADDR_WIDTH=10 → same word (alias).
- `MEMRead`=`MEMWrite`=1 to 0x30 with data 0x5 → word=0x5 and no Valid ever asserted.
- Assert `rst` while in BUSY on a pending read → next cycle Valid=0 and state IDLE; `MEM_Req_Ready`=1 after reset drops, with no stale response.
